// File: rtl/vector_load_unit.sv
// vector_load_unit: unit-stride vector load engine feeding the vector register
// file write port. It issues 1, 2 or 4 word reads on a req/gnt/rvalid memory
// port, packs the responses into 128-bit write data at the lanes selected by
// the destination register, and emits a single write (or a load_err pulse).
// Optional build macro: AVA_LOAD_ALIGN_CHECK_EN rejects commands whose base
// address is not word aligned; otherwise the low address bits are ignored.
//
// state | meaning
// IDLE  | ready for a command, stale responses ignored
// REQ   | issuing word requests, responses may already be returning
// WAIT  | all requests granted, collecting the remaining responses
// WRITE | one-cycle register-file write, or load_err if any response failed
module vector_load_unit #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         start,
  output logic         ready,
  input  logic [31:0]  base_addr,
  input  logic [4:0]   vd_addr_in,
  input  logic [1:0]   vlmul_in,
  output logic         data_req,
  input  logic         data_gnt,
  output logic [31:0]  data_addr,
  input  logic         data_rvalid,
  input  logic [31:0]  data_rdata,
  input  logic         data_err,
  output logic [127:0] vd_data,
  output logic [4:0]   vd_addr,
  output logic [1:0]   vlmul,
  output logic         write,
  output logic         load_operation,
  output logic         load_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

  localparam logic [2:0] MAX_OS = 3'(MAX_OUTSTANDING);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] addr_q;
  logic [2:0]  n_q;
  logic [2:0]  issued_q;
  logic [2:0]  recv_q;
  logic [2:0]  recv_nxt;
  logic [2:0]  outstanding;
  logic [1:0]  lane_q;
  logic [1:0]  lane_wr;
  logic [2:0]  n_in;
  logic [1:0]  lane_in;
  logic        err_q;
  logic        err_pulse_q;
  logic        wr_err;
  logic        accept;
  logic        bad_cmd;
  logic        resp_fire;
  logic        grant_fire;

`ifdef AVA_LOAD_ALIGN_CHECK_EN
  assign bad_cmd = (vlmul_in == 2'd3) || (base_addr[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^base_addr[1:0];
  assign bad_cmd = (vlmul_in == 2'd3);
`endif

  assign accept      = start & ready;
  assign grant_fire  = data_req & data_gnt;
  // responses are only meaningful while a load is in flight
  assign resp_fire   = data_rvalid && ((state == REQ) || (state == WAIT)) && (recv_q < n_q);
  assign recv_nxt    = recv_q + {2'b00, resp_fire};
  assign outstanding = issued_q - recv_q;
  assign lane_wr     = lane_q + recv_q[1:0];
  assign data_addr   = addr_q;
  assign load_err    = err_pulse_q | wr_err;

  // word count and first destination lane decoded from the incoming command
  always_comb begin
    n_in    = 3'd1;
    lane_in = 2'd0;
    case (vlmul_in)
      2'd0: begin
        n_in    = 3'd1;
        lane_in = vd_addr_in[1:0];
      end
      2'd1: begin
        n_in    = 3'd2;
        lane_in = {vd_addr_in[1], 1'b0};
      end
      2'd2: begin
        n_in    = 3'd4;
        lane_in = 2'd0;
      end
      default: begin
        n_in    = 3'd1;
        lane_in = 2'd0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state and control outputs
  always_comb begin
    state_nxt      = state;
    ready          = 1'b0;
    data_req       = 1'b0;
    write          = 1'b0;
    load_operation = 1'b0;
    wr_err         = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start && !bad_cmd) state_nxt = REQ;
      end
      REQ: begin
        data_req = (issued_q < n_q) && (outstanding < MAX_OS);
        // a response landing in the same cycle as the last grant counts here
        if (data_req && data_gnt && ((issued_q + 3'd1) == n_q))
          state_nxt = (recv_nxt == n_q) ? WRITE : WAIT;
      end
      WAIT: begin
        if (recv_nxt == n_q) state_nxt = WRITE;
      end
      WRITE: begin
        write          = !err_q;
        load_operation = !err_q;
        wr_err         = err_q;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // command latch, request address/count tracking and response assembly
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      addr_q      <= 32'd0;
      n_q         <= 3'd1;
      lane_q      <= 2'd0;
      issued_q    <= 3'd0;
      recv_q      <= 3'd0;
      err_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      vd_data     <= 128'd0;
      vd_addr     <= 5'd0;
      vlmul       <= 2'd0;
    end else begin
      err_pulse_q <= accept & bad_cmd;
      if (accept) begin
        addr_q   <= {base_addr[31:2], 2'b00};
        n_q      <= n_in;
        lane_q   <= lane_in;
        issued_q <= 3'd0;
        recv_q   <= 3'd0;
        err_q    <= 1'b0;
        vd_data  <= 128'd0;
        vd_addr  <= vd_addr_in;
        vlmul    <= vlmul_in;
      end else begin
        if (grant_fire) begin
          addr_q   <= addr_q + 32'd4;
          issued_q <= issued_q + 3'd1;
        end
        if (resp_fire) begin
          vd_data[{lane_wr, 5'd0} +: 32] <= data_rdata;
          recv_q <= recv_q + 3'd1;
          if (data_err) err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_load_unit.sv
// Scoreboard bench for vector_load_unit: commands push their expected
// completion into a queue, a memory model answers requests, and a monitor
// compares every write / load_err against the queue head.
module tb_vector_load_unit;

  localparam int MAX_OS = 2;

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic         start = 1'b0;
  logic         ready;
  logic [31:0]  base_addr = 32'd0;
  logic [4:0]   vd_addr_in = 5'd0;
  logic [1:0]   vlmul_in = 2'd0;
  logic         data_req;
  logic         data_gnt = 1'b0;
  logic [31:0]  data_addr;
  logic         data_rvalid = 1'b0;
  logic [31:0]  data_rdata = 32'd0;
  logic         data_err = 1'b0;
  logic [127:0] vd_data;
  logic [4:0]   vd_addr;
  logic [1:0]   vlmul;
  logic         write;
  logic         load_operation;
  logic         load_err;

  vector_load_unit #(.MAX_OUTSTANDING(MAX_OS)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .ready(ready),
    .base_addr(base_addr), .vd_addr_in(vd_addr_in), .vlmul_in(vlmul_in),
    .data_req(data_req), .data_gnt(data_gnt), .data_addr(data_addr),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .data_err(data_err),
    .vd_data(vd_data), .vd_addr(vd_addr), .vlmul(vlmul), .write(write),
    .load_operation(load_operation), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic         err;
    logic [127:0] data;
    logic [4:0]   vd;
    logic [1:0]   lm;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } resp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  resp_t       pend[$];

  // memory behaviour knobs, set per command by the stimulus
  int          mode = 1;     // 0 random, 1 zero-wait, 2 slow grants
  logic [31:0] data_xor = 32'd0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'd0;
  bit          stale_req = 1'b0;

  int          outst = 0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  int          req_age = 0;

  // memory model: grants, in-order responses, request protocol checks
  always @(negedge clk) begin
    logic  g;
    int    extra;
    resp_t r;
    logic [31:0] ea;
    if (!n_reset) begin
      pend.delete();
      outst       = 0;
      prev_wait   = 1'b0;
      req_age     = 0;
      data_gnt    = 1'b0;
      data_rvalid = 1'b0;
      data_err    = 1'b0;
      data_rdata  = 32'd0;
    end else begin
      data_gnt = 1'b0;
      if (data_req) begin
        if (prev_wait) chk("addr_stable", data_addr, prev_addr);
        case (mode)
          1:       g = 1'b1;
          2:       g = (req_age >= 3);
          default: g = ($urandom_range(0, 1) == 1);
        endcase
        if (g) begin
          chk("outstanding_limit", outst < MAX_OS, 1'b1);
          if (addr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_req: got addr %h expected no request", data_addr);
          end else begin
            ea = addr_q.pop_front();
            chk("req_addr", data_addr, ea);
          end
          extra  = (mode == 1) ? 0 : (mode == 2) ? 1 : $urandom_range(0, 2);
          r.data = data_addr ^ data_xor;
          r.err  = err_en && (data_addr == err_addr);
          r.due  = cyc + 1 + extra;
          pend.push_back(r);
          outst++;
          prev_wait = 1'b0;
          req_age   = 0;
        end else begin
          prev_wait = 1'b1;
          prev_addr = data_addr;
          req_age++;
        end
        data_gnt = g;
      end else begin
        if (prev_wait) chk("req_held", data_req, 1'b1);
        prev_wait = 1'b0;
        req_age   = 0;
      end
      data_rvalid = 1'b0;
      data_err    = 1'b0;
      data_rdata  = 32'd0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        data_rvalid = 1'b1;
        data_rdata  = r.data;
        data_err    = r.err;
        outst--;
      end else if (stale_req && pend.size() == 0) begin
        data_rvalid = 1'b1;
        data_rdata  = 32'hDEAD_BEEF;
        data_err    = 1'b1;
        stale_req   = 1'b0;
      end
    end
  end

  // completion monitor
  always @(negedge clk) begin
    exp_t e;
    if (n_reset && (write || load_err || load_operation)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_completion: got write=%0b load_err=%0b expected none", write, load_err);
      end else begin
        e = exp_q.pop_front();
        chk("write", write, !e.err);
        chk("load_operation", load_operation, !e.err);
        chk("load_err", load_err, e.err);
        if (e.cyc >= 0) chk("latency", cyc, e.cyc);
        if (!e.err) begin
          chk("vd_data", vd_data, e.data);
          chk("vd_addr", vd_addr, e.vd);
          chk("vlmul", vlmul, e.lm);
        end
        done_cnt++;
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got ready=0 expected 1");
    end
  endtask

  task automatic check_reset_values();
    chk("rst_ready", ready, 1'b1);
    chk("rst_data_req", data_req, 1'b0);
    chk("rst_write", write, 1'b0);
    chk("rst_load_op", load_operation, 1'b0);
    chk("rst_load_err", load_err, 1'b0);
    chk("rst_data_addr", data_addr, 32'd0);
    chk("rst_vd_data", vd_data, 128'd0);
    chk("rst_vd_addr", vd_addr, 5'd0);
    chk("rst_vlmul", vlmul, 2'd0);
  endtask

  task automatic run_cmd(input logic [31:0] base, input logic [4:0] vd, input logic [1:0] lm,
                         input int err_idx, input int m, input logic [31:0] xr);
    exp_t        e;
    int          n;
    int          fl;
    int          lat;
    int          target;
    logic [31:0] ab;
    logic        rejected;
    n  = (lm == 2'd0) ? 1 : (lm == 2'd1) ? 2 : 4;
    fl = (lm == 2'd0) ? int'(vd[1:0]) : (lm == 2'd1) ? int'({vd[1], 1'b0}) : 0;
    ab = {base[31:2], 2'b00};
    rejected = (lm == 2'd3);
`ifdef AVA_LOAD_ALIGN_CHECK_EN
    if (base[1:0] != 2'b00) rejected = 1'b1;
`endif
    wait_ready();
    mode     = m;
    data_xor = xr;
    err_en   = (err_idx >= 0) && (err_idx < n) && !rejected;
    err_addr = ab + 32'(4 * err_idx);
    e.data   = 128'd0;
    if (!rejected)
      for (int k = 0; k < n; k++) begin
        addr_q.push_back(ab + 32'(4 * k));
        e.data[32 * (fl + k) +: 32] = (ab + 32'(4 * k)) ^ xr;
      end
    e.err = rejected || err_en;
    e.vd  = vd;
    e.lm  = lm;
    lat   = rejected ? 1 : (m == 1) ? n + 2 : (m == 2) ? 4 * n + 3 : -1;
    e.cyc = (lat < 0) ? -1 : cyc + lat;
    exp_q.push_back(e);
    target     = done_cnt + 1;
    base_addr  = base;
    vd_addr_in = vd;
    vlmul_in   = lm;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ready_after_accept", ready, rejected);
    for (int i = 0; i < 400 && done_cnt < target; i++) @(negedge clk);
    if (done_cnt < target) begin
      tests++;
      fails++;
      $display("FAIL completion_timeout: got %0d completions expected %0d", done_cnt, target);
      exp_q.delete();
      addr_q.delete();
    end
  endtask

  initial begin
    logic [31:0] b;
    logic [1:0]  lm;
    int          ei;
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    n_reset = 1'b1;
    @(negedge clk);

    run_cmd(32'h0000_0100, 5'd5, 2'd0, -1, 1, 32'hAABB_CDDD);
    run_cmd(32'h0000_0200, 5'd8, 2'd2, -1, 1, 32'h0);
    run_cmd(32'h0000_0300, 5'd6, 2'd1, -1, 2, 32'h1234_5678);
    run_cmd(32'h0000_0400, 5'd3, 2'd2, 1, 1, 32'h0F0F_0000);

    // abort a 4-word load after two grants, then feed a stale response
    wait_ready();
    mode     = 1;
    data_xor = 32'd0;
    err_en   = 1'b0;
    for (int k = 0; k < 4; k++) addr_q.push_back(32'h800 + 32'(4 * k));
    base_addr  = 32'h800;
    vd_addr_in = 5'd4;
    vlmul_in   = 2'd2;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 n_reset = 1'b0;
    addr_q.delete();
    @(negedge clk);
    check_reset_values();
    @(negedge clk);
    n_reset   = 1'b1;
    stale_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("stale_vd_data", vd_data, 128'd0);
    chk("stale_ready", ready, 1'b1);
    chk("stale_data_req", data_req, 1'b0);

    run_cmd(32'h0000_0500, 5'd9, 2'd2, -1, 1, 32'h5555_0000);
    run_cmd(32'h0000_0102, 5'd0, 2'd0, -1, 1, 32'h0000_00FF);
    run_cmd(32'h0000_0600, 5'd1, 2'd3, -1, 1, 32'h0);
    run_cmd(32'hFFFF_FFF8, 5'd13, 2'd2, -1, 0, 32'hC0DE_0000);

    for (int t = 0; t < 40; t++) begin
      b = $urandom;
      if ($urandom_range(0, 3) != 0) b[1:0] = 2'b00;
      lm = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ei = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_cmd(b, 5'($urandom), lm, ei, int'($urandom_range(0, 2)), $urandom);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("addr_queue_drained", addr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    tests++;
    fails++;
    $display("FAIL watchdog: got no end of test expected completion before time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
